// File: rtl/tpu_pkg.sv
// Shared definitions for the systolic-array edge blocks: default array geometry and
// the output deskew FSM state type.
package tpu_pkg;

  localparam int DEFAULT_N      = 2;
  localparam int DEFAULT_DATA_W = 32;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } deskew_state_t;

endpackage

// File: rtl/deskew_column.sv
// One array column of the output deskew: row counter plus N-entry row storage.
// A clear restarts the column; a beat accepted together with a clear lands in row 0.
module deskew_column
  import tpu_pkg::*;
#(
  parameter int N      = DEFAULT_N,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        accept_i,
  input  logic                        clear_i,
  input  logic [DATA_W-1:0]           din_i,
  output logic                        full_o,
  output logic [$clog2(N+1)-1:0]      cnt_o,
  output logic [N*DATA_W-1:0]         rows_o
);

  localparam int CW = $clog2(N+1);

  logic [CW-1:0]       rcnt_q, rcnt_d;
  logic [N*DATA_W-1:0] rows_q, rows_d;
  logic [CW-1:0]       wr_idx;

  // Next row count and row-storage write for this column
  always_comb begin
    rcnt_d = rcnt_q;
    rows_d = rows_q;
    wr_idx = clear_i ? '0 : rcnt_q;
    if (clear_i) begin
      rcnt_d = '0;
    end
    if (accept_i) begin
      rcnt_d = wr_idx + CW'(1);
      for (int r = 0; r < N; r++) begin
        if (wr_idx == CW'(r)) begin
          rows_d[r*DATA_W +: DATA_W] = din_i;
        end
      end
    end
  end

  // Column state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rcnt_q <= '0;
      rows_q <= '0;
    end else begin
      rcnt_q <= rcnt_d;
      rows_q <= rows_d;
    end
  end

  assign full_o = (rcnt_q == CW'(N));
  assign cnt_o  = rcnt_q;
  assign rows_o = rows_q;

endmodule

// File: rtl/output_deskew.sv
// Output deskew: re-aligns the staggered per-column results of the systolic array
// into one row-major NxN frame presented with a valid/ready handshake.
// Optional feature: define DESKEW_TIMEOUT_EN to abandon partial frames that do not
// complete within TIMEOUT cycles of becoming busy (sticky timeout flag).
module output_deskew
  import tpu_pkg::*;
#(
  parameter int N       = DEFAULT_N,
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N*DATA_W-1:0]     c_in,
  input  logic [N-1:0]            c_valid,
  output logic [N*N*DATA_W-1:0]   c_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    overflow,
  output logic                    timeout
);

  localparam int CW = $clog2(N+1);

  deskew_state_t       state_q, state_d;
  logic                overflow_q, overflow_d;
  logic [N-1:0]        full, acc_collect, accept, fill_last;
  logic [CW-1:0]       cnt [N];
  logic [N*DATA_W-1:0] rows [N];
  logic                hs, clear, complete, abandon, any_cnt;

  for (genvar j = 0; j < N; j++) begin : g_col
    deskew_column #(.N(N), .DATA_W(DATA_W)) u_col (
      .clk      (clk),
      .reset    (reset),
      .accept_i (accept[j]),
      .clear_i  (clear),
      .din_i    (c_in[j*DATA_W +: DATA_W]),
      .full_o   (full[j]),
      .cnt_o    (cnt[j]),
      .rows_o   (rows[j])
    );
    for (genvar i = 0; i < N; i++) begin : g_row
      assign c_out[(i*N+j)*DATA_W +: DATA_W] = rows[j][i*DATA_W +: DATA_W];
    end
  end

  assign out_valid = (state_q == HOLD);
  assign hs        = out_valid && out_ready;
  assign clear     = hs || abandon;
  assign busy      = (state_q == COLLECT) && any_cnt;
  assign complete  = (state_q == COLLECT) && (&fill_last);
  assign overflow  = overflow_q;

  // Normal-collection acceptance and "column full after this edge" per column
  always_comb begin
    acc_collect = '0;
    fill_last   = '0;
    any_cnt     = 1'b0;
    for (int j = 0; j < N; j++) begin
      acc_collect[j] = c_valid[j] && (state_q == COLLECT) && !full[j];
      fill_last[j]   = full[j] || (acc_collect[j] && (cnt[j] == CW'(N-1)));
      any_cnt        = any_cnt || (cnt[j] != '0);
    end
  end

  // Restart cycles (handshake or abandon) take every presented beat as row 0
  always_comb begin
    accept = acc_collect | (c_valid & {N{clear}});
  end

  // FSM next state and sticky drop flag
  always_comb begin
    state_d    = state_q;
    overflow_d = overflow_q | (|(c_valid & ~accept));
    case (state_q)
      COLLECT: if (complete) state_d = HOLD;
      HOLD:    if (out_ready) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  // FSM state and overflow registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= COLLECT;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef DESKEW_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT+1);

  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          timeout_q, timeout_d;

  // Frame age counter; reaching TIMEOUT abandons the partial frame
  always_comb begin
    tcnt_d    = tcnt_q;
    timeout_d = timeout_q;
    abandon   = 1'b0;
    if (!busy || complete) begin
      tcnt_d = '0;
    end else if (tcnt_q == TW'(TIMEOUT-1)) begin
      abandon   = 1'b1;
      timeout_d = 1'b1;
      tcnt_d    = '0;
    end else begin
      tcnt_d = tcnt_q + TW'(1);
    end
  end

  // Timeout counter and sticky flag registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      tcnt_q    <= tcnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_timeout_param;

  assign abandon              = 1'b0;
  assign timeout              = 1'b0;
  assign unused_timeout_param = ^TIMEOUT;
`endif

endmodule

// File: tb/tb_output_deskew.sv
// Self-checking bench for output_deskew (N=2, DATA_W=32, TIMEOUT=16).
module tb_output_deskew;

  localparam int N  = 2;
  localparam int DW = 32;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [N*DW-1:0]   c_in = '0;
  logic [N-1:0]      c_valid = '0;
  logic [N*N*DW-1:0] c_out;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              busy;
  logic              overflow;
  logic              timeout;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [DW-1:0] m_mat [N*N];
  int            m_cnt [N];
  logic          m_hold;
  logic          m_ovf;
  logic          m_to;
  int            m_age;

  output_deskew #(.N(N), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .c_in      (c_in),
    .c_valid   (c_valid),
    .c_out     (c_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .overflow  (overflow),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [N*N*DW-1:0] m_cout();
    logic [N*N*DW-1:0] r;
    for (int k = 0; k < N*N; k++) r[k*DW +: DW] = m_mat[k];
    return r;
  endfunction

  function automatic logic m_busy();
    int s = 0;
    for (int j = 0; j < N; j++) s += m_cnt[j];
    return !m_hold && (s != 0);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N*N; k++) m_mat[k] = '0;
    for (int j = 0; j < N; j++) m_cnt[j] = 0;
    m_hold = 1'b0; m_ovf = 1'b0; m_to = 1'b0; m_age = 0;
  endtask

  // One clock of the specification's behaviour, applied to the model
  task automatic model_step(input logic [N-1:0] v, input logic [DW-1:0] d0,
                            input logic [DW-1:0] d1, input logic rdy);
    logic [DW-1:0] d [N];
    logic busy0, complete, abandon;
    d[0] = d0; d[1] = d1;
    busy0 = m_busy();
    if (m_hold) begin
      m_age = 0;
      if (rdy) begin
        m_hold = 1'b0;
        for (int j = 0; j < N; j++) begin
          m_cnt[j] = 0;
          if (v[j]) begin m_mat[j] = d[j]; m_cnt[j] = 1; end
        end
      end else if (v != '0) begin
        m_ovf = 1'b1;
      end
    end else begin
      complete = 1'b1;
      for (int j = 0; j < N; j++)
        if (m_cnt[j] + ((v[j] && m_cnt[j] < N) ? 1 : 0) != N) complete = 1'b0;
      abandon = 1'b0;
`ifdef DESKEW_TIMEOUT_EN
      if (busy0 && !complete) begin
        m_age++;
        if (m_age == TO) begin abandon = 1'b1; m_to = 1'b1; m_age = 0; end
      end else begin
        m_age = 0;
      end
`endif
      for (int j = 0; j < N; j++) begin
        if (abandon) begin
          m_cnt[j] = 0;
          if (v[j]) begin m_mat[j] = d[j]; m_cnt[j] = 1; end
        end else if (v[j]) begin
          if (m_cnt[j] < N) begin m_mat[m_cnt[j]*N + j] = d[j]; m_cnt[j]++; end
          else m_ovf = 1'b1;
        end
      end
      if (complete) m_hold = 1'b1;
    end
  endtask

  // Drive one cycle of inputs, advance the model, settle past the edge
  task automatic cyc(input logic [N-1:0] v, input logic [DW-1:0] d0,
                     input logic [DW-1:0] d1, input logic rdy);
    c_valid = v; c_in = {d1, d0}; out_ready = rdy;
    @(posedge clk);
    model_step(v, d0, d1, rdy);
    #1;
    c_valid = '0; out_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; c_valid = '0; c_in = '0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; c_valid = 2'b11; c_in = {32'hDEAD, 32'hBEEF}; out_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (c_out !== '0) begin bad++; $display("FAIL reset_cout got=%0h exp=0", c_out); end
    total++; if ({out_valid, busy, overflow, timeout} !== 4'b0) begin
      bad++; $display("FAIL reset_flags got=%b exp=0000", {out_valid, busy, overflow, timeout}); end
    do_reset();
  endtask

  task automatic test_staggered();
    do_reset();
    cyc(2'b01, 19, 0, 0);
    cyc(2'b11, 43, 22, 0);
    total++; if (out_valid !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL stag_mid got=%b%b exp=01", out_valid, busy); end
    cyc(2'b10, 0, 50, 0);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stag_valid got=%b exp=1", out_valid); end
    total++; if (c_out !== {32'd50, 32'd43, 32'd22, 32'd19}) begin
      bad++; $display("FAIL stag_cout got=%0h exp=%0h", c_out, {32'd50, 32'd43, 32'd22, 32'd19}); end
    total++; if (overflow !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL stag_flags got=%b%b exp=00", overflow, busy); end
    cyc(2'b00, 0, 0, 1);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stag_hs got=%b exp=0", out_valid); end
  endtask

  task automatic test_zero_skew();
    cyc(2'b11, 1, 2, 0);
    total++; if (out_valid !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL zs_mid got=%b%b exp=01", out_valid, busy); end
    cyc(2'b11, 3, 4, 0);
    total++; if (out_valid !== 1'b1 || c_out !== {32'd4, 32'd3, 32'd2, 32'd1}) begin
      bad++; $display("FAIL zs_frame got=%b %0h exp=1 %0h", out_valid, c_out, {32'd4, 32'd3, 32'd2, 32'd1}); end
  endtask

  task automatic test_back_to_back();
    // frame {1,2,3,4} is held from test_zero_skew
    for (int k = 0; k < 5; k++) begin
      cyc((k == 2) ? 2'b01 : 2'b00, 7, 0, 0);
      total++; if (out_valid !== 1'b1 || c_out !== {32'd4, 32'd3, 32'd2, 32'd1}) begin
        bad++; $display("FAIL bp_hold%0d got=%b %0h", k, out_valid, c_out); end
    end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL bp_ovf got=%b exp=1", overflow); end
    cyc(2'b11, 8, 9, 1);
    total++; if (out_valid !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL bp_hs got=%b%b exp=01", out_valid, busy); end
    cyc(2'b11, 10, 11, 0);
    total++; if (out_valid !== 1'b1 || c_out !== {32'd11, 32'd10, 32'd9, 32'd8}) begin
      bad++; $display("FAIL bp_next got=%b %0h exp=1 %0h", out_valid, c_out, {32'd11, 32'd10, 32'd9, 32'd8}); end
    cyc(2'b00, 0, 0, 1);
  endtask

  task automatic test_overrun();
    do_reset();
    cyc(2'b01, 5, 0, 0);
    cyc(2'b11, 6, 20, 0);
    cyc(2'b01, 7, 0, 0);
    total++; if (overflow !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL or_drop got=%b%b exp=10", overflow, out_valid); end
    cyc(2'b10, 0, 21, 0);
    total++; if (out_valid !== 1'b1 || c_out !== {32'd21, 32'd6, 32'd20, 32'd5}) begin
      bad++; $display("FAIL or_frame got=%b %0h exp=1 %0h", out_valid, c_out, {32'd21, 32'd6, 32'd20, 32'd5}); end
    cyc(2'b00, 0, 0, 1);
  endtask

  task automatic test_async_reset();
    do_reset();
    cyc(2'b01, 33, 0, 0);
    #2 reset = 1'b1;
    #1;
    model_reset();
    total++; if ({c_out, out_valid, busy, overflow, timeout} !== '0) begin
      bad++; $display("FAIL ar_zero got=%0h %b%b%b%b exp=0", c_out, out_valid, busy, overflow, timeout); end
    @(negedge clk);
    reset = 1'b0;
    cyc(2'b11, 32'hA5A5A5A5, 32'h5A5A5A5A, 0);
    cyc(2'b11, 32'hFFFFFFFF, 32'h80000000, 0);
    total++; if (out_valid !== 1'b1 ||
                 c_out !== {32'h80000000, 32'hFFFFFFFF, 32'h5A5A5A5A, 32'hA5A5A5A5}) begin
      bad++; $display("FAIL ar_frame got=%b %0h", out_valid, c_out); end
    cyc(2'b00, 0, 0, 1);
  endtask

  task automatic test_timeout();
    do_reset();
    cyc(2'b01, 44, 0, 0);
`ifdef DESKEW_TIMEOUT_EN
    for (int k = 1; k < TO; k++) cyc(2'b00, 0, 0, 0);
    total++; if (timeout !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL to_early got=%b%b exp=01", timeout, busy); end
    cyc(2'b00, 0, 0, 0);
    total++; if (timeout !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL to_fire got=%b%b exp=10", timeout, busy); end
    cyc(2'b11, 1, 2, 0);
    cyc(2'b11, 3, 4, 0);
    total++; if (out_valid !== 1'b1 || c_out !== {32'd4, 32'd3, 32'd2, 32'd1}) begin
      bad++; $display("FAIL to_frame got=%b %0h", out_valid, c_out); end
`else
    for (int k = 0; k < 20; k++) cyc(2'b00, 0, 0, 0);
    total++; if (timeout !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL to_wait got=%b%b exp=01", timeout, busy); end
    cyc(2'b11, 45, 60, 0);
    cyc(2'b10, 0, 61, 0);
    total++; if (out_valid !== 1'b1 || c_out !== {32'd61, 32'd45, 32'd60, 32'd44}) begin
      bad++; $display("FAIL to_frame got=%b %0h", out_valid, c_out); end
`endif
    cyc(2'b00, 0, 0, 1);
  endtask

  task automatic test_random();
    logic [N-1:0] v;
    do_reset();
    for (int k = 0; k < 600; k++) begin
      v = ($urandom_range(0, 3) == 0) ? 2'b00 : N'($urandom_range(0, 3));
      if ((k / 100) % 2 == 1 && $urandom_range(0, 5) != 0) v = 2'b00;
      cyc(v, $urandom, $urandom, ($urandom_range(0, 2) != 0));
      total++; if (c_out !== m_cout()) begin
        bad++; $display("FAIL rnd_cout k=%0d got=%0h exp=%0h", k, c_out, m_cout()); end
      total++; if ({out_valid, busy, overflow, timeout} !== {m_hold, m_busy(), m_ovf, m_to}) begin
        bad++; $display("FAIL rnd_flags k=%0d got=%b exp=%b", k,
                        {out_valid, busy, overflow, timeout}, {m_hold, m_busy(), m_ovf, m_to}); end
    end
  endtask

  initial begin
    test_reset();
    test_staggered();
    test_zero_skew();
    test_back_to_back();
    test_overrun();
    test_async_reset();
    test_timeout();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
